// File: rtl/jam_cost_sequencer_if.sv
// Bundles the requester handshake and the cost-table lookup port of jam_cost_sequencer.
// Master drives requests, permutations and the Cost response; slave is the sequencer.
interface jam_cost_sequencer_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*24-1:0] perm;
  logic [NREQ-1:0]    gnt;
  logic [2:0]         W;
  logic [2:0]         J;
  logic [6:0]         Cost;
  logic [NREQ-1:0]    done;
  logic [9:0]         sum_out;
  logic               busy;
  logic [1:0]         state_dbg;

  // Handshake: a requester holds req (level) until its done pulse; gnt is one-hot
  // for the whole burst and done pulses for exactly one cycle at burst end.
  modport master (
    output req, perm, Cost,
    input  gnt, W, J, done, sum_out, busy, state_dbg
  );

  modport slave (
    input  req, perm, Cost,
    output gnt, W, J, done, sum_out, busy, state_dbg
  );
endinterface

// File: rtl/jam_cost_sequencer.sv
// Round-robin arbiter that walks one 8-entry worker/job assignment through the shared
// cost table per burst and returns the accumulated cost with a one-cycle done pulse.
module jam_cost_sequencer #(
  parameter int NREQ = 2
) (
  input logic                 CLK,
  input logic                 RST_N,
  jam_cost_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [2:0]      beat_q, beat_d;
  logic [9:0]      acc_q, acc_d;
  logic [9:0]      sum_q, sum_d;
  logic [23:0]     perm_q, perm_d;
  logic            busy_q, busy_d;

  logic [3:0]  req_ext;
  logic [95:0] perm_ext;
  logic [2:0]  cand;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [23:0] win_perm;
  logic [3:0]  win_onehot;
  logic [3:0]  done_onehot;
  logic [2:0]  ptr_inc;
  logic [9:0]  acc_sum;
  logic [4:0]  j_ofs;
  logic [2:0]  j_sel;

  // Widen to four requesters so 2-bit indices are always in range.
  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = bus.req;
    perm_ext = '0;
    perm_ext[NREQ*24-1:0] = bus.perm;
  end

  // First set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + 3'(i);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!win_found && req_ext[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_perm = perm_ext[23:0];
      2'd1:    win_perm = perm_ext[47:24];
      2'd2:    win_perm = perm_ext[71:48];
      default: win_perm = perm_ext[95:72];
    endcase
    win_onehot  = 4'b0001 << win_idx;
    done_onehot = 4'b0001 << gidx_q;
    ptr_inc     = {1'b0, gidx_q} + 3'd1;
    acc_sum     = acc_q + {3'b000, bus.Cost};
    j_ofs       = {1'b0, beat_q, 1'b0} + {2'b00, beat_q};
    j_sel       = perm_q[j_ofs +: 3];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    perm_d  = perm_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gidx_d  = win_idx;
          gnt_d   = win_onehot[NREQ-1:0];
          perm_d  = win_perm;
          beat_d  = 3'd0;
          acc_d   = 10'd0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // beat wraps back to 0 after beat 7, so W reads 0 outside RUN.
        acc_d  = acc_sum;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          sum_d   = acc_sum;
          done_d  = done_onehot[NREQ-1:0];
          gnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = '0;
        busy_d  = 1'b0;
        ptr_d   = (ptr_inc == 3'(NREQ)) ? 2'd0 : ptr_inc[1:0];
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gidx_q  <= 2'd0;
      gnt_q   <= '0;
      done_q  <= '0;
      beat_q  <= 3'd0;
      acc_q   <= 10'd0;
      sum_q   <= 10'd0;
      perm_q  <= 24'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      perm_q  <= perm_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.sum_out   = sum_q;
  assign bus.W         = beat_q;
  assign bus.J         = (state_q == S_RUN) ? j_sel : 3'd0;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_jam_cost_sequencer.sv
// Directed plus randomized bench for jam_cost_sequencer: a table-driven cost model and
// a round-robin reference predict winner, W/J walk and burst sum for every burst.
module tb_jam_cost_sequencer;

  localparam int NREQ = 2;

  logic clk;
  logic rst_n;

  jam_cost_sequencer_if #(.NREQ(NREQ)) bus ();

  jam_cost_sequencer #(.NREQ(NREQ)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  logic [6:0]      cost_tbl [64];
  logic [2:0]      job_m [NREQ][8];
  logic [NREQ-1:0] req_m;
  int              ptr_m;
  logic [9:0]      exp_q [$];
  int              n_cmp;
  int              n_bad;
  int              order_log [$];

  always_comb bus.Cost = cost_tbl[{bus.W, bus.J}];

  // ---------------- driver tasks ----------------
  task automatic drive();
    logic [NREQ*24-1:0] p;
    p = '0;
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++)
        p = p | ((NREQ*24)'(job_m[r][k]) << (r*24 + k*3));
    bus.perm = p;
    bus.req  = req_m;
  endtask

  task automatic rand_perms();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++)
        job_m[r][k] = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_table();
    for (int i = 0; i < 64; i++) cost_tbl[i] = 7'($urandom_range(0, 127));
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (ptr_m + i) % NREQ;
      if (((req_m >> c) & 1) != 0) return c;
    end
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    return NREQ'(1) << w;
  endfunction

  // Entered at an IDLE-cycle negedge with req_m already driven; returns at the
  // negedge after the DONE cycle (IDLE again).
  task automatic burst(input bit mutate, input bit rearm);
    int         w;
    logic [9:0] exp_sum;
    logic [2:0] lat [8];
    w = pick();
    exp_sum = '0;
    for (int k = 0; k < 8; k++) begin
      lat[k]  = job_m[w][k];
      exp_sum = exp_sum + 10'(cost_tbl[k*8 + int'(lat[k])]);
    end
    exp_q.push_back(exp_sum);
    order_log.push_back(w);
    @(negedge clk);
    check("grant", 32'(bus.gnt), 32'(onehot(w)));
    check("busy_run", 32'(bus.busy), 32'd1);
    if (mutate) begin
      for (int k = 0; k < 8; k++) job_m[w][k] = ~lat[k];
      req_m[w] = 1'b0;
      drive();
    end
    for (int k = 0; k < 8; k++) begin
      check("beat_w", 32'(bus.W), 32'(k));
      check("beat_j", 32'(bus.J), 32'(lat[k]));
      check("done_idle", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    check("done_pulse", 32'(bus.done), 32'(onehot(w)));
    check("gnt_off", 32'(bus.gnt), 32'd0);
    check("sum_out", 32'(bus.sum_out), 32'(exp_q.pop_front()));
    req_m[w] = 1'b0;
    drive();
    ptr_m = (w + 1) % NREQ;
    @(negedge clk);
    check("done_clear", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("gnt_idle", 32'(bus.gnt), 32'd0);
    check("w_idle", 32'(bus.W), 32'd0);
    if (rearm) begin
      req_m[w] = 1'b1;
      drive();
    end
  endtask

  // ---------------- stimulus and scoreboard ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    ptr_m = 0;
    req_m = '0;
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++) job_m[r][k] = 3'(k);
    for (int i = 0; i < 64; i++) cost_tbl[i] = 7'(i);
    rst_n = 1'b0;
    drive();
    #23;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_w", 32'(bus.W), 32'd0);
    check("rst_j", 32'(bus.J), 32'd0);
    check("rst_sum", 32'(bus.sum_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // both requesters right after reset: 0 then 1
    rand_table();
    rand_perms();
    req_m = '1;
    drive();
    burst(0, 0);
    burst(0, 0);

    // continuous demand: each re-raises after its done
    req_m = '1;
    drive();
    order_log.delete();
    for (int b = 0; b < 4; b++) begin
      rand_perms();
      drive();
      burst(0, 1);
    end
    for (int b = 0; b < 4; b++) check("rr_order", 32'(order_log[b]), 32'(b % 2));
    req_m = '0;
    drive();
    @(negedge clk);

    // identity perm with Cost = 8*W + J
    for (int i = 0; i < 64; i++) cost_tbl[i] = 7'(i);
    for (int k = 0; k < 8; k++) job_m[0][k] = 3'(k);
    req_m = 2'b01;
    drive();
    burst(0, 0);
    check("sum_identity", 32'(bus.sum_out), 32'd252);

    // saturated table: no wrap
    for (int i = 0; i < 64; i++) cost_tbl[i] = 7'd127;
    rand_perms();
    req_m = 2'b01;
    drive();
    burst(0, 0);
    check("sum_max", 32'(bus.sum_out), 32'h3F8);

    // reset during beat 4 of requester 1's burst
    rand_table();
    rand_perms();
    req_m = '1;
    drive();
    @(negedge clk);
    check("pre_rst_gnt", 32'(bus.gnt), 32'(onehot(1)));
    repeat (4) @(negedge clk);
    check("pre_rst_w", 32'(bus.W), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sum", 32'(bus.sum_out), 32'd0);
    check("abort_j", 32'(bus.J), 32'd0);
    req_m = '0;
    drive();
    @(negedge clk);
    check("abort_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    check("no_done_after", 32'(bus.done), 32'd0);
    req_m = '1;
    drive();
    burst(0, 0);
    req_m = '0;
    drive();
    @(negedge clk);

    // perm changed and req dropped one cycle after the grant edge
    rand_table();
    rand_perms();
    req_m = onehot(ptr_m);
    drive();
    burst(1, 0);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) rand_table();
      rand_perms();
      req_m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drive();
      burst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        req_m = '0;
        drive();
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jam_cost_sequencer.md
# jam_cost_sequencer

Sequencer and arbiter for the shared worker/job cost table used by the job-assignment search. Up to NREQ permutation engines each request evaluation of one 8-entry assignment (a permutation of jobs 0..7). The block grants the single W/J/Cost lookup port to one requester at a time in round-robin order and walks W = 0..7 with J = perm[W]. It accumulates the total cost and returns it to the winner with a one-cycle done pulse.

## Interface
Parameters:
- NREQ, 2: number of requesters, legal range 2..4.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester burst request (level).
- perm  in  NREQ*24  per-requester assignment; requester r's job for worker k = perm[r*24 + k*3 +: 3].
- gnt  out  NREQ  one-hot grant, high for the whole burst.
- W  out  3  worker index to cost table.
- J  out  3  job index to cost table.
- Cost  in  7  cost table data, combinational response to W/J within the same cycle.
- done  out  NREQ  one-cycle pulse to the granted requester at burst end.
- sum_out  out  10  total cost of the last completed burst; held until next done.
- busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high at the clock edge, choose the winner g: the first set req bit searching from ptr upward, modulo NREQ.
  - Latch perm[g*24 +: 24] into an internal 24-bit register, set gnt[g], clear beat and acc, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - W = beat, J = latched_perm[beat*3 +: 3].
  - Each edge: acc <= acc + Cost, beat <= beat + 1.
  - At the edge that ends beat 7: sum_out <= acc + Cost, done[g] <= 1, gnt <= 0, go to DONE.
- DONE: ptr <= (g+1) mod NREQ; go to IDLE. done deasserts at the edge leaving DONE.
- W and J are 0 outside RUN.
- Arithmetic: acc and sum_out are 10 bits unsigned. The maximum 8*127 = 1016 cannot overflow.
- The perm value is not validated; duplicate jobs are summed as given.
- A requester must deassert req during the cycle its done is high. If req is still high at the edge ending the IDLE cycle that follows, that counts as a new request.
- Dropping req during RUN is ignored: the burst completes and done still pulses.
- Changing perm after the grant edge has no effect on the current burst.
- Requests arriving during RUN/DONE wait; req is not registered or queued beyond its level.
- NREQ values outside 2..4 are unsupported.

## Timing
- Reset (RST_N low, asynchronous, at any time including mid-burst):
  - State IDLE; gnt = 0, done = 0, W = 0, J = 0, sum_out = 0, busy = 0.
  - ptr = 0; beat, acc and the latched perm are cleared.
  - No done is issued for an aborted burst.
- Latency, with E0 as the edge where req is sampled in IDLE:
  - gnt is high from E0 to E8; beat k is the cycle after E(k), for k = 0..7.
  - done and sum_out update at E8; busy is low again after E9.
- Throughput: one burst per 10 cycles (IDLE + 8 RUN + DONE) under continuous demand.
- gnt, done, W, J and busy are driven from registers, except J, which is a mux of registered beat and latched perm. Nothing depends combinationally on req or Cost.

## Test plan
- Single request, NREQ=2, table Cost = 8*W + J, perm identity (J = W), req[0] raised: gnt = 2'b01 for 8 cycles, W/J walk 0..7, done[0] pulses at E8, sum_out = 252.
- req = 2'b11 right after reset, held until each done: requester 0 is served first. gnt[1] rises one cycle after done[0] falls, and sum_out is updated per burst.
- Both req held continuously for 4 bursts, requesters dropping req only on their own done: grant order is 0,1,0,1, with no two consecutive grants to the same requester.
- Every Cost = 127 with any perm: sum_out = 1016 (10'h3F8), no wrap.
- RST_N pulsed low during beat 4 of a burst: gnt and busy drop immediately, done never pulses for that burst, sum_out = 0, and the next request after reset is granted from ptr = 0.
- perm changed and req dropped one cycle after the grant edge: W/J follow the latched perm, sum_out matches the original perm, and done still pulses at E8.
